// File: rtl/axi4_mem_slave_pkg.sv
// axi4_mem_slave_pkg: response codes, FSM state types and the burst error rule shared by the slave
package axi4_mem_slave_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  function automatic logic burst_err(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                                     input int unsigned szl, input int unsigned depth);
    int unsigned beats, first;
    beats = 32'(len) + 1;
    first = addr >> szl;
    return (size != 3'(szl)) || (32'(addr[11:0]) + (beats << size) > 32'd4096) || (first + 32'(len) >= depth);
  endfunction
endpackage

// File: rtl/axi4_mem_slave_if.sv
// axi4_mem_slave_if: AXI4 AW/W/B/AR/R channel bundle with master and slave views
interface axi4_mem_slave_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 16);
  logic [ADDR_WIDTH-1:0] AWADDR, ARADDR;
  logic [7:0]            AWLEN, ARLEN;
  logic [2:0]            AWSIZE, ARSIZE;
  logic [DATA_WIDTH-1:0] WDATA, RDATA;
  logic [1:0]            BRESP, RRESP;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVAILD, BREADY;
  logic ARVALID, ARREADY, RLAST, RVAILD, RREADY;
  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVAILD, ARREADY, RDATA, RRESP, RLAST, RVAILD
  );
  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
    output ARADDR, ARLEN, ARSIZE, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVAILD, ARREADY, RDATA, RRESP, RLAST, RVAILD
  );
endinterface

// File: rtl/axi4_mem_slave_bank.sv
// axi4_mem_slave_bank: one write port, one registered read port, read returns old data on collision
module axi4_mem_slave_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int AW         = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 INCR-burst memory slave with independent write and read engines
//  ACLK clock, ARESTN async active-high reset, bus: AW/W/B write channels and AR/R read channels
module axi4_mem_slave
  import axi4_mem_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input logic              ACLK,
  input logic              ARESTN,
  axi4_mem_slave_if.slave  bus
);
  localparam int SZL = $clog2(DATA_WIDTH / 8);
  localparam int MAW = $clog2(MEM_DEPTH);
  wr_state_e w_state_q, w_state_d;
  rd_state_e r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d, r_idx_q, r_idx_d;
  logic [7:0] w_len_q, w_len_d, r_len_q, r_len_d;
  logic [8:0] w_beat_q, w_beat_d, r_beat_q, r_beat_d;
  logic w_err_q, w_err_d, r_err_q, r_err_d;
  logic live_q, we, re, w_last, r_last;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // live_q keeps the address channels closed while reset is held
  assign bus.AWREADY = live_q && w_state_q == W_IDLE;
  assign bus.WREADY  = w_state_q == W_DATA;
  assign bus.BVAILD  = w_state_q == W_RESP;
  assign bus.BRESP   = (w_state_q == W_RESP && w_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign bus.ARREADY = live_q && r_state_q == R_IDLE;
  assign bus.RVAILD  = r_state_q == R_DATA;
  assign bus.RLAST   = r_state_q == R_DATA && r_last;
  assign bus.RRESP   = (r_state_q == R_DATA && r_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign bus.RDATA   = r_err_q ? '0 : mem_rdata;
  assign w_last = w_beat_q == {1'b0, w_len_q};
  assign r_last = r_beat_q == {1'b0, r_len_q};
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    we        = 1'b0;
    if (w_state_q == W_IDLE && bus.AWVALID && bus.AWREADY) begin
      w_idx_d   = bus.AWADDR >> SZL;
      w_len_d   = bus.AWLEN;
      w_beat_d  = '0;
      w_err_d   = burst_err(32'(bus.AWADDR), bus.AWLEN, bus.AWSIZE, SZL, MEM_DEPTH);
      w_state_d = W_DATA;
    end
    if (w_state_q == W_DATA && bus.WVALID) begin
      // a misplaced WLAST poisons the burst but the beat count still decides where it ends
      w_err_d   = w_err_q || (bus.WLAST != w_last);
      we        = !w_err_d;
      w_idx_d   = w_idx_q + ADDR_WIDTH'(1);
      w_beat_d  = w_beat_q + 9'd1;
      w_state_d = w_last ? W_RESP : W_DATA;
    end
    if (w_state_q == W_RESP && bus.BREADY) w_state_d = W_IDLE;
  end
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_err_d   = r_err_q;
    re        = 1'b0;
    if (r_state_q == R_IDLE && bus.ARVALID && bus.ARREADY) begin
      r_idx_d   = bus.ARADDR >> SZL;
      r_len_d   = bus.ARLEN;
      r_beat_d  = '0;
      r_err_d   = burst_err(32'(bus.ARADDR), bus.ARLEN, bus.ARSIZE, SZL, MEM_DEPTH);
      re        = 1'b1;
      r_state_d = R_DATA;
    end
    if (r_state_q == R_DATA && bus.RREADY) begin
      r_state_d = r_last ? R_IDLE : R_DATA;
      r_idx_d   = r_last ? r_idx_q : r_idx_q + ADDR_WIDTH'(1);
      r_beat_d  = r_last ? r_beat_q : r_beat_q + 9'd1;
      re        = !r_last;
    end
  end
  always_ff @(posedge ACLK or posedge ARESTN)
    if (ARESTN) begin
      live_q    <= 1'b0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_err_q   <= 1'b0;
    end else begin
      live_q    <= 1'b1;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_err_q   <= r_err_d;
    end
  axi4_mem_slave_bank #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH), .AW(MAW)) u_bank (
    .clk   (ACLK),
    .rst   (ARESTN),
    .we    (we),
    .waddr (w_idx_q[MAW-1:0]),
    .wdata (bus.WDATA),
    .re    (re),
    .raddr (r_idx_d[MAW-1:0]),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave: randomized burst traffic against a word-array memory model with per-scenario checks
module tb_axi4_mem_slave;
  localparam int DW = 32, AW = 16, DEPTH = 1024;
  logic ACLK = 1'b0;
  logic ARESTN = 1'b1;
  int unsigned passed = 0, total = 0;
  logic [DW-1:0] model [DEPTH];
  always #5 ACLK = ~ACLK;
  axi4_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  axi4_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .ACLK   (ACLK),
    .ARESTN (ARESTN),
    .bus    (bus)
  );
  function automatic bit model_err(input int unsigned addr, input int unsigned len, input int unsigned size);
    return size != 2 || (addr % 4096) + (len + 1) * (1 << size) > 4096 || addr / 4 + len >= DEPTH;
  endfunction
  function automatic logic [41:0] outs();
    return {bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVAILD, bus.RVAILD, bus.RLAST, bus.BRESP, bus.RRESP, bus.RDATA};
  endfunction
  task automatic write_burst(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input int early, input int hold, input int base, input string tag);
    logic [DW-1:0] d;
    bit err;
    err = model_err(addr, len, size) || (early >= 0 && early != int'(len));
    bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWVALID = 1'b1;
    total++;
    if (bus.AWREADY !== 1'b1) $display("FAIL %s awready got %b want 1", tag, bus.AWREADY); else passed++;
    @(negedge ACLK);
    bus.AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      d = base < 0 ? DW'($urandom) : DW'(base + b);
      bus.WDATA = d; bus.WVALID = 1'b1;
      bus.WLAST = early >= 0 ? (b == early) : (b == int'(len));
      total++;
      if (bus.WREADY !== 1'b1) $display("FAIL %s wready beat %0d got %b want 1", tag, b, bus.WREADY); else passed++;
      if (!err) model[addr / 4 + b] = d;
      @(negedge ACLK);
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      bus.BREADY = i == hold;
      total++;
      if ({bus.BVAILD, bus.BRESP} !== {1'b1, err ? 2'b10 : 2'b00})
        $display("FAIL %s bresp cycle %0d got bvalid=%b bresp=%b want bvalid=1 bresp=%b", tag, i, bus.BVAILD, bus.BRESP, err ? 2'b10 : 2'b00);
      else passed++;
      @(negedge ACLK);
    end
    bus.BREADY = 1'b0;
    total++;
    if ({bus.BVAILD, bus.AWREADY} !== 2'b01) $display("FAIL %s after b got bvalid=%b awready=%b want 0 1", tag, bus.BVAILD, bus.AWREADY); else passed++;
  endtask
  task automatic read_burst(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input int stall, input string tag);
    bit err;
    int b, cyc;
    logic [DW+3:0] exp_r, got_r;
    err = model_err(addr, len, size);
    bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARVALID = 1'b1;
    total++;
    if (bus.ARREADY !== 1'b1) $display("FAIL %s arready got %b want 1", tag, bus.ARREADY); else passed++;
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    b = 0; cyc = 0;
    while (b <= int'(len) && cyc < 2000) begin
      cyc++;
      bus.RREADY = $urandom_range(99) >= stall;
      exp_r = {1'b1, b == int'(len), err ? 2'b10 : 2'b00, err ? '0 : model[addr / 4 + b]};
      got_r = {bus.RVAILD, bus.RLAST, bus.RRESP, bus.RDATA};
      total++;
      if (got_r !== exp_r) $display("FAIL %s r beat %0d got v/l/resp/data=%h want %h", tag, b, got_r, exp_r); else passed++;
      if (bus.RREADY) b++;
      @(negedge ACLK);
    end
    bus.RREADY = 1'b0;
    total++;
    if (b != int'(len) + 1 || {bus.RVAILD, bus.ARREADY} !== 2'b01)
      $display("FAIL %s r end got beats=%0d rvalid=%b arready=%b want beats=%0d 0 1", tag, b, bus.RVAILD, bus.ARREADY, int'(len) + 1);
    else passed++;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge ACLK);
    total++;
    if (outs() !== '0) $display("FAIL reset outputs got %h want 0", outs()); else passed++;
    ARESTN = 1'b0;
    @(negedge ACLK);
    total++;
    if ({bus.AWREADY, bus.ARREADY} !== 2'b11) $display("FAIL reset_release ready got %b want 11", {bus.AWREADY, bus.ARREADY}); else passed++;
  endtask
  task automatic test_basic;
    write_burst(16'h0010, 8'd3, 3'd2, -1, 0, 32'hA0, "basic_w");
    read_burst(16'h0010, 8'd3, 3'd2, 0, "basic_r");
  endtask
  task automatic test_errors;
    write_burst(16'h0FF8, 8'd1, 3'd2, -1, 0, -1, "edge_w");
    write_burst(16'h0FF8, 8'd3, 3'd2, -1, 0, -1, "cross_w");
    read_burst(16'h0FF8, 8'd1, 3'd2, 0, "nowrite_r");
    read_burst(16'h0FF8, 8'd3, 3'd2, 0, "cross_r");
    write_burst(16'h0020, 8'd0, 3'd1, -1, 0, -1, "size_w");
    read_burst(16'h1000, 8'd0, 3'd2, 0, "depth_r");
  endtask
  task automatic test_wlast_bhold;
    write_burst(16'h0300, 8'd3, 3'd2, 2, 5, -1, "wlast_w");
  endtask
  task automatic test_random;
    logic [15:0] a;
    logic [7:0] l;
    logic [2:0] s;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, 16'h13FF)) & 16'hFFFC;
      l = 8'($urandom_range(0, 15));
      s = $urandom_range(0, 5) == 0 ? 3'd1 : 3'd2;
      write_burst(a, l, s, -1, $urandom_range(0, 2), -1, "rand_w");
      read_burst(a, l, s, 30, "rand_r");
    end
  endtask
  task automatic test_long_read;
    write_burst(16'h0400, 8'd255, 3'd2, -1, 0, -1, "long_w");
    read_burst(16'h0400, 8'd255, 3'd2, 50, "long_r");
  endtask
  task automatic test_reset_mid;
    bus.AWADDR = 16'h0200; bus.AWLEN = 8'd7; bus.AWSIZE = 3'd2; bus.AWVALID = 1'b1;
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b1; bus.WDATA = 32'hDEAD0000; bus.WLAST = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESTN = 1'b1; bus.WVALID = 1'b0;
    #1;
    total++;
    if (outs() !== '0) $display("FAIL midreset outputs got %h want 0", outs()); else passed++;
    @(negedge ACLK);
    ARESTN = 1'b0;
    @(negedge ACLK);
    total++;
    if ({bus.AWREADY, bus.BVAILD, bus.WREADY} !== 3'b100) $display("FAIL midreset release got aw/b/w=%b want 100", {bus.AWREADY, bus.BVAILD, bus.WREADY}); else passed++;
    write_burst(16'h0200, 8'd3, 3'd2, -1, 0, -1, "post_w");
    read_burst(16'h0200, 8'd3, 3'd2, 20, "post_r");
  endtask
  initial begin
    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    test_reset;
    test_basic;
    test_errors;
    test_wlast_bhold;
    test_random;
    test_long_read;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached after %0d/%0d checks", passed, total);
    $fatal(1);
  end
endmodule
